multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences the shared register file, ALU, immediate extender and single unified memory across fetch, decode, execute, memory and writeback cycles.
- Selects sign or zero extension per instruction.
- Counts retired instructions.
- Waits on a memory ready handshake.

Parameters:
- CNT_WIDTH, 32, width of retired-instruction counter
- STATE_W, 4, width of state encoding exported on state_o

Ports:
- clk_i  input  1  system clock, all state updates on rising edge
- rst_i  input  1  synchronous reset, active high
- instr_op_i  input  6  opcode field of the instruction register
- funct_i  input  6  funct field (R-type); passed to ALU control, unused for sequencing
- zero_i  input  1  ALU zero flag
- mem_ready_i  input  1  memory completes current access this cycle
- pc_write_o  output  1  PC load enable
- iord_o  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read_o  output  1  memory read request
- mem_write_o  output  1  memory write request
- ir_write_o  output  1  instruction register load
- reg_dst_o  output  1  write register: 0=rt, 1=rd
- mem_to_reg_o  output  1  writeback data: 0=ALUOut, 1=MDR
- reg_write_o  output  1  register file write enable
- alu_src_a_o  output  1  0=PC, 1=reg A
- alu_src_b_o  output  2  00=reg B, 01=const 4, 10=ext imm, 11=ext imm<<2
- alu_op_o  output  2  00=add, 01=sub, 10=by funct, 11=by opcode (immediate ops)
- pc_source_o  output  2  00=ALU result, 01=ALUOut, 10=jump target
- ext_sel_o  output  1  1=sign extend, 0=zero extend
- state_o  output  STATE_W  current state, debug
- instr_cnt_o  output  CNT_WIDTH  retired instruction count

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11. Encodings 12-15 are unreachable; decoding any of them goes to FETCH.
- Outputs are combinational from the state, plus zero_i and mem_ready_i where stated. Any output not listed for a state is 0.
- Reset, while rst_i=1:
  - All enables are forced 0: pc_write, mem_read, mem_write, ir_write, reg_write.
  - Next state is FETCH; instr_cnt_o is cleared to 0.
  - Reset mid-access abandons the access with no write.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - If mem_ready_i=1: ir_write=1, pc_write=1, next DECODE. Otherwise stay in FETCH with no PC or IR update.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, ext_sel=1 (branch target precompute).
  - Next state by opcode: 0x23/0x2B → MEM_ADDR; 0x00 → R_EXEC; 0x04/0x05 → BRANCH; 0x02 → JUMP; 0x08/0x0A/0x0D → I_EXEC.
  - Any other opcode retires as a NOP: counter +1, next FETCH, no writes.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_sel=1, alu_op=00. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Advance to MEM_WB when mem_ready_i=1, else hold.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Retire; next FETCH.
- MEM_WR: mem_write=1, iord=1.
  - mem_write stays high until mem_ready_i=1.
  - The ready cycle retires the instruction; next FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retire; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - pc_write = zero_i for beq; pc_write = !zero_i for bne.
  - Retire; next FETCH.
- JUMP: pc_source=10, pc_write=1. Retire; next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11; ext_sel=0 for ori (0x0D), 1 otherwise. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Retire; next FETCH.
- ext_sel_o defaults to 1 in every state not listed above.
- Counter:
  - Increments by exactly 1 on each retirement cycle.
  - Wraps modulo 2^CNT_WIDTH with no saturation.
  - Holds while stalled on mem_ready_i.
- Memory is never requested for read and write in the same cycle.
- At most one of reg_write, mem_write is high per cycle.
- Cycle counts with no stall: lw 5; sw 4; R-type 4; addi/slti/ori 4; beq/bne 3; j 3; illegal opcode 2.

Test Plan:
- Reset, then rst_i=0 with mem_ready_i=1 and opcode 0x00 → states 0,1,6,7,0. reg_write=1, reg_dst=1 in state 7 only; instr_cnt_o=1 after 4 cycles.
- lw (0x23) with mem_ready_i low for 3 cycles in MEM_RD → stays in state 3 for 4 cycles with mem_read=1, iord=1. Then MEM_WB with mem_to_reg=1; counter +1 only once.
- beq (0x04): zero_i=1 → pc_write=1 in BRANCH. Repeat with zero_i=0 → pc_write=0. bne with zero_i=0 → pc_write=1. Each retires in 3 cycles.
- ori (0x0D) → ext_sel_o=0 and alu_op=11 in I_EXEC. addi (0x08) → ext_sel_o=1 in I_EXEC.
- Opcode 0x3F → DECODE returns to FETCH, no reg_write or mem_write, counter +1. Then assert rst_i during MEM_WR with mem_ready_i=0 → mem_write drops in the reset cycle, state_o=0 next cycle, counter=0.
- Preload the counter near wrap by running 2^CNT_WIDTH retirements (bench built with CNT_WIDTH=4): 16 R-type instructions → instr_cnt_o wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback over shared resources and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_WIDTH = 32,
  parameter int STATE_W   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [5:0]           instr_op_i,
  input  logic [5:0]           funct_i,
  input  logic                 zero_i,
  input  logic                 mem_ready_i,
  output logic                 pc_write_o,
  output logic                 iord_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic                 ir_write_o,
  output logic                 reg_dst_o,
  output logic                 mem_to_reg_o,
  output logic                 reg_write_o,
  output logic                 alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [1:0]           alu_op_o,
  output logic [1:0]           pc_source_o,
  output logic                 ext_sel_o,
  output logic [STATE_W-1:0]   state_o,
  output logic [CNT_WIDTH-1:0] instr_cnt_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t state;
  state_t state_next;
  logic   retire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= FETCH;
      instr_cnt_o <= '0;
    end else begin
      state <= state_next;
      if (retire)
        instr_cnt_o <= instr_cnt_o + 1'b1;
    end
  end

  assign state_o = STATE_W'(state);

  always_comb begin
    state_next   = FETCH;
    retire       = 1'b0;
    pc_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    pc_source_o  = 2'b00;
    ext_sel_o    = 1'b1;

    case (state)
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_next = DECODE;
        end else begin
          state_next = FETCH;
        end
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        case (instr_op_i)
          OP_LW, OP_SW:             state_next = MEM_ADDR;
          OP_RTYPE:                 state_next = R_EXEC;
          OP_BEQ, OP_BNE:           state_next = BRANCH;
          OP_J:                     state_next = JUMP;
          OP_ADDI, OP_SLTI, OP_ORI: state_next = I_EXEC;
          default: begin
            state_next = FETCH;
            retire     = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_next  = (instr_op_i == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        state_next = mem_ready_i ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire       = 1'b1;
      end
      MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        retire      = mem_ready_i;
        state_next  = mem_ready_i ? FETCH : MEM_WR;
      end
      R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
        state_next  = R_WB;
      end
      R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retire      = 1'b1;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b01;
        pc_source_o = 2'b01;
        pc_write_o  = (instr_op_i == OP_BNE) ? !zero_i : zero_i;
        retire      = 1'b1;
      end
      JUMP: begin
        pc_source_o = 2'b10;
        pc_write_o  = 1'b1;
        retire      = 1'b1;
      end
      I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = 2'b11;
        ext_sel_o   = (instr_op_i != OP_ORI);
        state_next  = I_WB;
      end
      I_WB: begin
        reg_write_o = 1'b1;
        retire      = 1'b1;
      end
      default: state_next = FETCH;
    endcase

    // Reset masks every enable so an in-flight access is abandoned cleanly.
    if (rst_i) begin
      pc_write_o  = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      ir_write_o  = 1'b0;
      reg_write_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction sequences push the
// expected per-cycle state/controls/count; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MADDR = 4'd2,
    S_MRD = 4'd3, S_MWB = 4'd4, S_MWR = 4'd5, S_REX = 4'd6, S_RWB = 4'd7,
    S_BR = 4'd8, S_J = 4'd9, S_IEX = 4'd10, S_IWB = 4'd11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] op = 6'h00;
  logic [5:0] funct = 6'h00;
  logic zero = 1'b0;
  logic ready = 1'b1;
  logic pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic reg_write, alu_src_a, ext_sel;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [CW-1:0] cnt;

  multicycle_ctrl #(.CNT_WIDTH(CW), .STATE_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op), .funct_i(funct),
    .zero_i(zero), .mem_ready_i(ready),
    .pc_write_o(pc_write), .iord_o(iord), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .ir_write_o(ir_write), .reg_dst_o(reg_dst),
    .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .pc_source_o(pc_source), .ext_sel_o(ext_sel), .state_o(state),
    .instr_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int step_no = 0;
  logic [CW-1:0] exp_cnt = '0;

  // Control vector {pcw,iord,mrd,mwr,irw,rdst,m2r,rw,srca,srcb,aluop,pcsrc,ext}
  // written out from the state table of the controller.
  function automatic logic [15:0] ctrl_of(input logic [3:0] s, input logic [5:0] o,
                                          input logic z, input logic rdy, input logic r);
    logic pcw, io, mr, mw, irw, rd, m2r, rw, sa, ext;
    logic [1:0] sb, ao, ps;
    {pcw, io, mr, mw, irw, rd, m2r, rw, sa, ext} = 10'b0000000001;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (s)
      S_FETCH:  begin mr = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
      S_DECODE: sb = 2'b11;
      S_MADDR:  begin sa = 1; sb = 2'b10; end
      S_MRD:    begin mr = 1; io = 1; end
      S_MWB:    begin rw = 1; m2r = 1; end
      S_MWR:    begin mw = 1; io = 1; end
      S_REX:    begin sa = 1; ao = 2'b10; end
      S_RWB:    begin rw = 1; rd = 1; end
      S_BR:     begin sa = 1; ao = 2'b01; ps = 2'b01; pcw = (o == 6'h05) ? !z : z; end
      S_J:      begin ps = 2'b10; pcw = 1; end
      S_IEX:    begin sa = 1; sb = 2'b10; ao = 2'b11; ext = (o != 6'h0D); end
      S_IWB:    rw = 1;
      default:  ;
    endcase
    if (r) {pcw, mr, mw, irw, rw} = 5'b0;
    return {pcw, io, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, ext};
  endfunction

  // Drive one cycle's inputs, queue the expected outputs, advance to next cycle.
  task automatic cyc(input logic r, input logic [5:0] o, input logic z,
                     input logic rdy, input logic [3:0] es);
    exp_t e;
    rst = r; op = o; zero = z; ready = rdy;
    e.step = step_no; e.st = es; e.ctrl = ctrl_of(es, o, z, rdy, r); e.cnt = exp_cnt;
    q.push_back(e);
    step_no++;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = q.pop_front();
      act = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_op, pc_source, ext_sel};
      checks++;
      if (state !== e.st) begin
        failures++;
        $display("FAIL state step=%0d actual=%0d required=%0d", e.step, state, e.st);
      end
      checks++;
      if (act !== e.ctrl) begin
        failures++;
        $display("FAIL ctrl step=%0d actual=%b required=%b", e.step, act, e.ctrl);
      end
      checks++;
      if (cnt !== e.cnt) begin
        failures++;
        $display("FAIL instr_cnt step=%0d actual=%0d required=%0d", e.step, cnt, e.cnt);
      end
    end
  end

  task automatic rtype();
    cyc(0, 6'h00, 0, 1, S_FETCH);
    cyc(0, 6'h00, 0, 1, S_DECODE);
    cyc(0, 6'h00, 0, 1, S_REX);
    cyc(0, 6'h00, 0, 1, S_RWB);
    exp_cnt++;
  endtask

  task automatic branch(input logic [5:0] o, input logic z);
    cyc(0, o, z, 1, S_FETCH);
    cyc(0, o, z, 1, S_DECODE);
    cyc(0, o, z, 1, S_BR);
    exp_cnt++;
  endtask

  task automatic imm(input logic [5:0] o);
    cyc(0, o, 0, 1, S_FETCH);
    cyc(0, o, 0, 1, S_DECODE);
    cyc(0, o, 0, 1, S_IEX);
    cyc(0, o, 0, 1, S_IWB);
    exp_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    // Reset held with FETCH active: all enables masked, counter zero.
    cyc(1, 6'h00, 0, 1, S_FETCH);

    rtype();
    // lw with three stall cycles in MEM_RD
    cyc(0, 6'h23, 0, 1, S_FETCH);
    cyc(0, 6'h23, 0, 1, S_DECODE);
    cyc(0, 6'h23, 0, 1, S_MADDR);
    cyc(0, 6'h23, 0, 0, S_MRD);
    cyc(0, 6'h23, 0, 0, S_MRD);
    cyc(0, 6'h23, 0, 0, S_MRD);
    cyc(0, 6'h23, 0, 1, S_MRD);
    cyc(0, 6'h23, 0, 1, S_MWB);
    exp_cnt++;

    branch(6'h04, 1);
    branch(6'h04, 0);
    branch(6'h05, 0);
    branch(6'h05, 1);
    imm(6'h0D);
    imm(6'h08);
    imm(6'h0A);

    cyc(0, 6'h02, 0, 1, S_FETCH);
    cyc(0, 6'h02, 0, 1, S_DECODE);
    cyc(0, 6'h02, 0, 1, S_J);
    exp_cnt++;

    // sw with one stall, then a fetch stall
    cyc(0, 6'h2B, 0, 1, S_FETCH);
    cyc(0, 6'h2B, 0, 1, S_DECODE);
    cyc(0, 6'h2B, 0, 1, S_MADDR);
    cyc(0, 6'h2B, 0, 0, S_MWR);
    cyc(0, 6'h2B, 0, 1, S_MWR);
    exp_cnt++;
    cyc(0, 6'h00, 0, 0, S_FETCH);
    cyc(0, 6'h00, 0, 0, S_FETCH);
    cyc(0, 6'h3F, 0, 1, S_FETCH);
    cyc(0, 6'h3F, 0, 1, S_DECODE);
    exp_cnt++;

    // Reset arriving mid-store abandons the write
    cyc(0, 6'h2B, 0, 1, S_FETCH);
    cyc(0, 6'h2B, 0, 1, S_DECODE);
    cyc(0, 6'h2B, 0, 1, S_MADDR);
    cyc(1, 6'h2B, 0, 0, S_MWR);
    exp_cnt = '0;

    for (int i = 0; i < 15; i++) rtype();
    cyc(0, 6'h00, 0, 1, S_FETCH);
    cyc(0, 6'h00, 0, 1, S_DECODE);
    cyc(0, 6'h00, 0, 1, S_REX);
    cyc(0, 6'h00, 0, 1, S_RWB);
    exp_cnt = 4'd0;
    cyc(0, 6'h00, 0, 1, S_FETCH);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
